// File: rtl/icache_tag_check.sv
// -----------------------------------------------------------------------------
// icache_tag_check
//
// Second stage of the L1 instruction-fetch pipeline. Holds the direct-mapped
// tag/valid array, decides hit or miss for the fetch presented by the data
// array, returns the addressed instruction word on a hit, and on a miss runs
// the line-fill handshake with memory before installing the returned line
// through the data array's update port.
//
// Ports:
//   clock_i, reset_i      clock (rising edge), asynchronous active-high reset
//   enable_i              valid fetch from the data array
//   tag_i/index_i/offset_i fetch address fields
//   cacheline_i           line read from the data array at index_i
//   invalidateAll_i       clear every valid bit (honoured in IDLE only)
//   memAck_i, memLine_i   memory returns the requested line
//   instr_o, instrValid_o extracted instruction, one-cycle valid pulse
//   memReq_o, memReqAddr_o line request (held until ack), line-aligned address
//   updateEnable_o, newCacheline_o, newIndex_o  data array write port
//   stall_o               upstream must hold and re-issue fetches
// -----------------------------------------------------------------------------
module icache_tag_check #(
  parameter int TAG_W    = 51,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 5,
  parameter int LINE_W   = 256,
  parameter int INSTR_W  = 32
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            enable_i,
  input  logic [TAG_W-1:0]                tag_i,
  input  logic [INDEX_W-1:0]              index_i,
  input  logic [OFFSET_W-1:0]             offset_i,
  input  logic [LINE_W-1:0]               cacheline_i,
  input  logic                            invalidateAll_i,
  input  logic                            memAck_i,
  input  logic [LINE_W-1:0]               memLine_i,
  output logic [INSTR_W-1:0]              instr_o,
  output logic                            instrValid_o,
  output logic                            memReq_o,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0] memReqAddr_o,
  output logic                            updateEnable_o,
  output logic [LINE_W-1:0]               newCacheline_o,
  output logic [INDEX_W-1:0]              newIndex_o,
  output logic                            stall_o
);

  localparam int NSETS  = 1 << INDEX_W;
  localparam int WORDS  = LINE_W / INSTR_W;
  localparam int WORD_W = $clog2(WORDS);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  // Word 0 is the most-significant INSTR_W bits of the line.
  function automatic logic [INSTR_W-1:0] sel_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_W-1:0] w);
    logic [INSTR_W-1:0] r;
    r = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (w == WORD_W'(i)) r = line[LINE_W-1-INSTR_W*i -: INSTR_W];
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [NSETS-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_mem [NSETS];
  logic [TAG_W-1:0]      miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]    miss_idx_q, miss_idx_d;
  logic [WORD_W-1:0]     miss_word_q, miss_word_d;
  logic [INSTR_W-1:0]    instr_q, instr_d;
  logic                  instr_vld_q, instr_vld_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  upd_en_q, upd_en_d;
  logic [LINE_W-1:0]     new_line_q, new_line_d;
  logic [INDEX_W-1:0]    new_idx_q, new_idx_d;
  logic                  stall_q, stall_d;
  logic                  tag_we;
  logic                  hit;
  logic [WORD_W-1:0]     fetch_word;
  logic                  unused_offset_bits;

  assign fetch_word         = offset_i[OFFSET_W-1 -: WORD_W];
  // Sub-word byte offset bits do not affect which instruction is returned.
  assign unused_offset_bits = ^offset_i[OFFSET_W-WORD_W-1:0];
  assign hit                = valid_q[index_i] && (tag_mem[index_i] == tag_i);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_tag_d  = miss_tag_q;
    miss_idx_d  = miss_idx_q;
    miss_word_d = miss_word_q;
    instr_d     = instr_q;
    instr_vld_d = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    upd_en_d    = 1'b0;
    new_line_d  = new_line_q;
    new_idx_d   = new_idx_q;
    stall_d     = stall_q;
    tag_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The hit decision uses the array as it stood before any invalidate
        // taking effect on this same edge.
        if (enable_i) begin
          if (hit) begin
            instr_d     = sel_word(cacheline_i, fetch_word);
            instr_vld_d = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_addr_d  = {tag_i, index_i, {OFFSET_W{1'b0}}};
            stall_d     = 1'b1;
            miss_tag_d  = tag_i;
            miss_idx_d  = index_i;
            miss_word_d = fetch_word;
            state_d     = REQ;
          end
        end
        if (invalidateAll_i) valid_d = '0;
      end
      REQ: begin
        if (memAck_i) begin
          mem_req_d   = 1'b0;
          new_line_d  = memLine_i;
          new_idx_d   = miss_idx_q;
          upd_en_d    = 1'b1;
          instr_d     = sel_word(memLine_i, miss_word_q);
          instr_vld_d = 1'b1;
          state_d     = FILL;
        end
      end
      FILL: begin
        // Direct-mapped: the set is overwritten regardless of its old tag.
        tag_we              = 1'b1;
        valid_d[miss_idx_q] = 1'b1;
        stall_d             = 1'b0;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_tag_q  <= '0;
      miss_idx_q  <= '0;
      miss_word_q <= '0;
      instr_q     <= '0;
      instr_vld_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      upd_en_q    <= 1'b0;
      new_line_q  <= '0;
      new_idx_q   <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_tag_q  <= miss_tag_d;
      miss_idx_q  <= miss_idx_d;
      miss_word_q <= miss_word_d;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      upd_en_q    <= upd_en_d;
      new_line_q  <= new_line_d;
      new_idx_q   <= new_idx_d;
      stall_q     <= stall_d;
    end
  end

  // Tag storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clock_i) begin
    if (tag_we) tag_mem[miss_idx_q] <= miss_tag_q;
  end

  assign instr_o        = instr_q;
  assign instrValid_o   = instr_vld_q;
  assign memReq_o       = mem_req_q;
  assign memReqAddr_o   = mem_addr_q;
  assign updateEnable_o = upd_en_q;
  assign newCacheline_o = new_line_q;
  assign newIndex_o     = new_idx_q;
  assign stall_o        = stall_q;

endmodule

// File: tb/tb_icache_tag_check.sv
module tb_icache_tag_check;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [50:0]  tag;
  logic [7:0]   index;
  logic [4:0]   offset;
  logic [255:0] cacheline;
  logic         inval;
  logic         mem_ack;
  logic [255:0] mem_line;
  logic [31:0]  instr;
  logic         instr_valid;
  logic         mem_req;
  logic [63:0]  mem_req_addr;
  logic         upd_en;
  logic [255:0] new_line;
  logic [7:0]   new_index;
  logic         stall;

  always #5 clk = ~clk;

  icache_tag_check dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .enable_i        (enable),
    .tag_i           (tag),
    .index_i         (index),
    .offset_i        (offset),
    .cacheline_i     (cacheline),
    .invalidateAll_i (inval),
    .memAck_i        (mem_ack),
    .memLine_i       (mem_line),
    .instr_o         (instr),
    .instrValid_o    (instr_valid),
    .memReq_o        (mem_req),
    .memReqAddr_o    (mem_req_addr),
    .updateEnable_o  (upd_en),
    .newCacheline_o  (new_line),
    .newIndex_o      (new_index),
    .stall_o         (stall)
  );

  localparam logic [255:0] L1 =
    256'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888;
  localparam logic [255:0] L2 =
    256'h00000000_11111111_22222222_33333333_44444444_55555555_66666666_77777777;

  int errors = 0;
  int checks = 0;

  logic [31:0]  exp_instr_q [$];
  logic [63:0]  exp_addr_q  [$];
  logic [7:0]   exp_fidx_q  [$];
  logic [255:0] exp_fline_q [$];
  logic         prev_req = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output event with no expected entry", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (instr_valid) begin
      if (exp_instr_q.size() == 0) unexpected("sb_instr");
      else chk("sb_instr", instr, exp_instr_q.pop_front());
    end
    if (mem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) unexpected("sb_req_addr");
      else chk("sb_req_addr", mem_req_addr, exp_addr_q.pop_front());
    end
    if (upd_en) begin
      if (exp_fidx_q.size() == 0) unexpected("sb_fill");
      else begin
        chk("sb_fill_index", new_index, exp_fidx_q.pop_front());
        chk("sb_fill_line", new_line, exp_fline_q.pop_front());
      end
    end
    prev_req = mem_req;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [50:0] t, input logic [7:0] i, input logic [4:0] o,
                       input logic [255:0] line);
    tag = t; index = i; offset = o; cacheline = line; enable = 1'b1;
    cyc();
    enable = 1'b0;
  endtask

  task automatic hit(input logic [50:0] t, input logic [7:0] i, input logic [4:0] o,
                     input logic [255:0] line, input logic [31:0] exp);
    exp_instr_q.push_back(exp);
    fetch(t, i, o, line);
    chk("hit_valid", instr_valid, 1);
    chk("hit_instr", instr, exp);
    chk("hit_no_req", mem_req, 0);
    chk("hit_no_stall", stall, 0);
  endtask

  task automatic miss(input logic [50:0] t, input logic [7:0] i, input logic [4:0] o,
                      input logic [63:0] exp_addr);
    exp_addr_q.push_back(exp_addr);
    fetch(t, i, o, L1);
    chk("miss_req", mem_req, 1);
    chk("miss_stall", stall, 1);
    chk("miss_addr", mem_req_addr, exp_addr);
    chk("miss_no_valid", instr_valid, 0);
  endtask

  task automatic ack(input logic [255:0] line, input logic [7:0] i, input logic [31:0] exp);
    exp_instr_q.push_back(exp);
    exp_fidx_q.push_back(i);
    exp_fline_q.push_back(line);
    mem_ack = 1'b1; mem_line = line;
    cyc();
    mem_ack = 1'b0;
    chk("fill_upd", upd_en, 1);
    chk("fill_index", new_index, i);
    chk("fill_instr", instr, exp);
    chk("fill_valid", instr_valid, 1);
    chk("fill_stall", stall, 1);
    chk("fill_req_drop", mem_req, 0);
    cyc();
    chk("post_fill_stall", stall, 0);
    chk("post_fill_upd", upd_en, 0);
    chk("post_fill_line_held", new_line, line);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; tag = '0; index = '0; offset = '0; cacheline = '0;
    inval = 1'b0; mem_ack = 1'b0; mem_line = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_upd", upd_en, 0);
    chk("rst_stall", stall, 0);
    chk("rst_instr", instr, 0);
    rst = 1'b0;
    cyc();

    // 1: cold miss and fill
    miss(51'd55, 8'd0, 5'd7, 64'h000000000006E000);
    cyc();
    chk("req_hold", mem_req, 1);
    ack(L1, 8'd0, 32'hEEEEEEEE);

    // 2: hits, including back-to-back
    hit(51'd55, 8'd0, 5'd28, L1, 32'h88888888);
    hit(51'd55, 8'd0, 5'd0,  L1, 32'hFFFFFFFF);
    hit(51'd55, 8'd0, 5'd4,  L1, 32'hEEEEEEEE);
    cyc();
    chk("hit_pulse_ends", instr_valid, 0);

    // 3: conflict miss, ack on the first REQ cycle
    miss(51'd56, 8'd0, 5'd12, 64'h0000000000070000);
    ack(L2, 8'd0, 32'h33333333);
    miss(51'd55, 8'd0, 5'd20, 64'h000000000006E000);

    // 4: ack held off while upstream keeps fetching
    for (int k = 0; k < 5; k++) begin
      tag = 51'd9; index = 8'd1; offset = 5'd0; enable = 1'b1;
      cyc();
      chk("req_steady", mem_req, 1);
      chk("req_addr_steady", mem_req_addr, 64'h000000000006E000);
      chk("req_no_valid", instr_valid, 0);
    end
    enable = 1'b0;
    ack(L1, 8'd0, 32'hAAAAAAAA);
    mem_ack = 1'b1; mem_line = L2;
    cyc();
    mem_ack = 1'b0;
    chk("idle_ack_no_upd", upd_en, 0);
    chk("idle_ack_no_req", mem_req, 0);
    chk("idle_ack_no_valid", instr_valid, 0);
    hit(51'd55, 8'd0, 5'd20, L1, 32'hAAAAAAAA);

    // 5: reset during REQ
    miss(51'd57, 8'd3, 5'd0, 64'h0000000000072060);
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_upd", upd_en, 0);
    mem_ack = 1'b1; mem_line = L2;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    mem_ack = 1'b0;
    chk("late_ack_no_upd", upd_en, 0);
    chk("late_ack_no_valid", instr_valid, 0);
    chk("late_ack_no_req", mem_req, 0);
    miss(51'd55, 8'd0, 5'd0, 64'h000000000006E000);
    ack(L1, 8'd0, 32'hFFFFFFFF);

    // 6: invalidate in IDLE with a concurrent hit, then invalidate in REQ
    inval = 1'b1;
    hit(51'd55, 8'd0, 5'd4, L1, 32'hEEEEEEEE);
    inval = 1'b0;
    miss(51'd55, 8'd0, 5'd8, 64'h000000000006E000);
    inval = 1'b1;
    cyc();
    chk("inval_req_hold", mem_req, 1);
    exp_instr_q.push_back(32'hDDDDDDDD);
    exp_fidx_q.push_back(8'd0);
    exp_fline_q.push_back(L1);
    mem_ack = 1'b1; mem_line = L1;
    cyc();
    mem_ack = 1'b0;
    chk("inval_fill_upd", upd_en, 1);
    cyc();
    inval = 1'b0;
    chk("inval_post_stall", stall, 0);
    hit(51'd55, 8'd0, 5'd8, L1, 32'hDDDDDDDD);

    repeat (3) cyc();
    chk("sb_drain_instr", exp_instr_q.size(), 0);
    chk("sb_drain_addr", exp_addr_q.size(), 0);
    chk("sb_drain_fill", exp_fidx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
